// File: rtl/multi_ch_trigger_gen.sv
// multi_ch_trigger_gen
//   Time-multiplexed trigger generator for ranging sensors. A sweep fires the
//   enabled channels in ascending order, one per slot. Each trigger line is
//   high for PULSE_US microseconds, and consecutive rises are SLOT_US apart.
//   A sweep is launched by a single-cycle start request (one-shot) or by en
//   (sweeps repeat back-to-back while en is high).
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           periodic sweep mode
//   start        one-shot sweep request (single-cycle pulse)
//   ch_mask      per-channel enables, latched at each sweep start
//   trigger      sensor trigger lines, one-hot or zero
//   trigger_tick one-cycle pulse on the first cycle of each trigger pulse
//   ch_idx       channel owning the current slot
//   busy         sweep in progress
//   sweep_done   one-cycle pulse when a sweep completes
module multi_ch_trigger_gen #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PULSE_US = 10,
    parameter int unsigned SLOT_US  = 60000,
    parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] trigger,
    output logic              trigger_tick,
    output logic [CH_W-1:0]   ch_idx,
    output logic              busy,
    output logic              sweep_done
);

    localparam int unsigned US_DIV = CLK_FREQ / 1_000_000;
    localparam int unsigned PRE_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int unsigned US_W   = $clog2(SLOT_US + 1);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(US_DIV - 1);
    localparam logic [US_W-1:0]  PULSE_LAST = US_W'(PULSE_US - 1);
    localparam logic [US_W-1:0]  SLOT_LAST  = US_W'(SLOT_US - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT
    } state_t;

    state_t            state;
    logic [PRE_W-1:0]  pre_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [NUM_CH-1:0] mask_lat;

    logic              low_any;
    logic [CH_W-1:0]   low_ch;
    logic              nxt_any;
    logic [CH_W-1:0]   nxt_ch;
    logic              us_wrap;
    logic              pulse_end;
    logic              slot_end;

    // Comparison-based decode keeps out-of-range indices harmless when
    // NUM_CH is not a power of two.
    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            v[i] = (32'(idx) == i);
        end
        return v;
    endfunction

    // low_*: first channel of a new sweep (live mask).
    // nxt_*: next latched channel strictly above the current slot.
    always_comb begin
        low_any = 1'b0;
        low_ch  = '0;
        nxt_any = 1'b0;
        nxt_ch  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_mask[i] && !low_any) begin
                low_any = 1'b1;
                low_ch  = CH_W'(i);
            end
            if (mask_lat[i] && (i > 32'(ch_idx)) && !nxt_any) begin
                nxt_any = 1'b1;
                nxt_ch  = CH_W'(i);
            end
        end
    end

    // The counters are cleared on the rise edge. At edge e after the rise
    // they hold e-1 cycles, so the last cycle of a span of K microseconds is
    // the one where the prescaler wraps with us_cnt == K-1.
    assign us_wrap   = (pre_cnt == PRE_LAST);
    assign pulse_end = us_wrap && (us_cnt == PULSE_LAST);
    assign slot_end  = us_wrap && (us_cnt == SLOT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pre_cnt      <= '0;
            us_cnt       <= '0;
            mask_lat     <= '0;
            trigger      <= '0;
            trigger_tick <= 1'b0;
            ch_idx       <= '0;
            busy         <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            trigger_tick <= 1'b0;
            sweep_done   <= 1'b0;

            if (state != S_IDLE) begin
                if (us_wrap) begin
                    pre_cnt <= '0;
                    us_cnt  <= us_cnt + 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start || en) begin
                        if (low_any) begin
                            mask_lat     <= ch_mask;
                            pre_cnt      <= '0;
                            us_cnt       <= '0;
                            trigger      <= onehot(low_ch);
                            trigger_tick <= 1'b1;
                            ch_idx       <= low_ch;
                            busy         <= 1'b1;
                            state        <= S_PULSE;
                        end else begin
                            sweep_done <= 1'b1;
                        end
                    end
                end

                S_PULSE: begin
                    if (pulse_end) begin
                        trigger <= '0;
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (slot_end) begin
                        if (nxt_any) begin
                            pre_cnt      <= '0;
                            us_cnt       <= '0;
                            trigger      <= onehot(nxt_ch);
                            trigger_tick <= 1'b1;
                            ch_idx       <= nxt_ch;
                            state        <= S_PULSE;
                        end else begin
                            sweep_done <= 1'b1;
                            // Periodic mode chains straight into the next
                            // sweep so busy never drops between sweeps.
                            if (en && low_any) begin
                                mask_lat     <= ch_mask;
                                pre_cnt      <= '0;
                                us_cnt       <= '0;
                                trigger      <= onehot(low_ch);
                                trigger_tick <= 1'b1;
                                ch_idx       <= low_ch;
                                state        <= S_PULSE;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    trigger <= '0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_ch_trigger_gen.sv
// Directed testbench for multi_ch_trigger_gen with a 4 MHz clock, 4 channels,
// 2 us pulses and 5 us slots (8-cycle pulses, 20-cycle slots). Cycle 0 is the
// edge that samples start/en; "cycle c" is the value visible #1 after edge
// c-1.
module tb_multi_ch_trigger_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic [3:0] ch_mask;
    logic [3:0] trigger;
    logic       trigger_tick;
    logic [1:0] ch_idx;
    logic       busy;
    logic       sweep_done;

    int n_checks;
    int n_pass;
    int cyc;

    multi_ch_trigger_gen #(
        .CLK_FREQ(4_000_000),
        .NUM_CH  (4),
        .PULSE_US(2),
        .SLOT_US (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .ch_mask     (ch_mask),
        .trigger     (trigger),
        .trigger_tick(trigger_tick),
        .ch_idx      (ch_idx),
        .busy        (busy),
        .sweep_done  (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hand-derived waveform for the 4'b1011 one-shot sweep.
    function automatic logic [3:0] oneshot_trig(input int c);
        if (c >= 1 && c <= 8)   return 4'b0001;
        if (c >= 21 && c <= 28) return 4'b0010;
        if (c >= 41 && c <= 48) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic run_oneshot(input bit perturb);
        ch_mask = 4'b1011;
        start   = 1'b1;
        cyc     = 0;
        for (int k = 0; k < 65; k++) begin
            step();
            if (cyc == 1) start = 1'b0;
            check("trig", 32'(trigger), 32'(oneshot_trig(cyc)));
            check("tick", 32'(trigger_tick), 32'(cyc == 1 || cyc == 21 || cyc == 41));
            check("busy", 32'(busy), 32'(cyc <= 60));
            check("done", 32'(sweep_done), 32'(cyc == 61));
            if (cyc == 1)  check("idx", 32'(ch_idx), 32'd0);
            if (cyc == 21) check("idx", 32'(ch_idx), 32'd1);
            if (cyc == 41) check("idx", 32'(ch_idx), 32'd3);
            if (perturb) begin
                if (cyc == 10) ch_mask = 4'b0100;
                if (cyc == 15) start = 1'b1;
                if (cyc == 16) start = 1'b0;
            end
        end
        ch_mask = 4'b1011;
        for (int k = 0; k < 5; k++) step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        en       = 1'b0;
        start    = 1'b0;
        ch_mask  = 4'b0000;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_trig", 32'(trigger), 32'd0);
        check("rst_tick", 32'(trigger_tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        check("rst_idx", 32'(ch_idx), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // One-shot sweep, then the same sweep with mask change and extra start
        run_oneshot(1'b0);
        run_oneshot(1'b1);

        // Periodic mode on channel 0, en dropped at cycle 30
        ch_mask = 4'b0001;
        en      = 1'b1;
        cyc     = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            check("p_trig", 32'(trigger),
                  32'((cyc >= 1 && cyc <= 8) || (cyc >= 21 && cyc <= 28)));
            check("p_tick", 32'(trigger_tick), 32'(cyc == 1 || cyc == 21));
            check("p_done", 32'(sweep_done), 32'(cyc == 21 || cyc == 41));
            check("p_busy", 32'(busy), 32'(cyc <= 40));
            if (cyc == 30) en = 1'b0;
        end
        for (int k = 0; k < 3; k++) step();

        // Empty mask
        ch_mask = 4'b0000;
        start   = 1'b1;
        cyc     = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (cyc == 1) start = 1'b0;
            check("e_trig", 32'(trigger), 32'd0);
            check("e_busy", 32'(busy), 32'd0);
            check("e_done", 32'(sweep_done), 32'(cyc == 1));
        end

        // Asynchronous reset mid-pulse
        ch_mask = 4'b1011;
        start   = 1'b1;
        cyc     = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (cyc == 1) start = 1'b0;
        end
        check("a_pre", 32'(trigger), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("a_trig", 32'(trigger), 32'd0);
        check("a_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            check("a_idle", 32'(trigger), 32'd0);
            check("a_ibusy", 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_ch_trigger_gen.md
Name: multi_ch_trigger_gen

Overview:
Parametrised successor to the single-channel periodic trigger tick generator, for ranging sensors such as HC-SR04-class ultrasonic sensors. It drives NUM_CH trigger lines in time-multiplexed sweeps so only one sensor fires per slot, which prevents acoustic crosstalk. It supports a one-shot sweep (start) and continuous periodic sweeps (en), with a per-channel enable mask. It sits between the control/register logic and the sensor trigger pins, and its trigger_tick/ch_idx outputs feed the echo-measurement blocks.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz; must be an integer multiple of 1_000_000.
NUM_CH, 4, number of trigger channels; range 1 to 16.
PULSE_US, 10, trigger high time in microseconds; must be at least 1.
SLOT_US, 60000, time per channel slot in microseconds, measured rise to rise; must be greater than PULSE_US.
CH_W, $clog2(NUM_CH) (minimum 1), width of ch_idx.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  periodic mode; while high, sweeps repeat back-to-back
start  in  1  one-shot sweep request, single-cycle pulse
ch_mask  in  NUM_CH  channel enables; latched at each sweep start
trigger  out  NUM_CH  sensor trigger lines; at most one bit high at a time
trigger_tick  out  1  1-cycle pulse in the first cycle of each trigger pulse
ch_idx  out  CH_W  index of the channel in the current slot
busy  out  1  high while a sweep is in progress
sweep_done  out  1  1-cycle pulse when a sweep completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs are 0. FSM is IDLE. Internal counters and the latched mask are cleared.
- Derived constants: US_DIV = CLK_FREQ/1_000_000. PULSE_CYC = PULSE_US*US_DIV. SLOT_CYC = SLOT_US*US_DIV.
- Timing counting: a prescaler runs 0..US_DIV-1 and emits a microsecond tick; a µs counter counts those ticks. Both restart at every slot start. Use a wide enough counter for SLOT_US; no overflow is allowed.
- FSM states are IDLE, PULSE and WAIT.
- IDLE, sweep start:
  - If (start | en) is sampled high at edge N and ch_mask != 0, latch ch_mask and select the lowest set bit.
  - From cycle N+1: trigger[ch] = 1, trigger_tick = 1 for that one cycle, ch_idx = ch, busy = 1. Go to PULSE.
- IDLE, empty mask: if (start | en) is high and ch_mask == 0, no trigger fires. sweep_done pulses at N+1, busy stays 0, and the FSM stays IDLE. With en held high this repeats every cycle.
- PULSE: trigger stays high for exactly PULSE_CYC cycles, then drops to 0. Go to WAIT.
- WAIT: lasts until SLOT_CYC cycles after the trigger rise. At the slot boundary:
  - Another latched channel above ch: the next-higher latched channel rises in the very next cycle, with no idle gap. The rise-to-rise spacing is exactly SLOT_CYC.
  - No higher channel: sweep_done pulses in the cycle after the last slot.
    - If en = 1 in that cycle: re-latch ch_mask and start a new sweep in that same cycle (trigger_tick coincides with sweep_done; busy stays 1). If the new mask is 0, fall to IDLE with busy = 0.
    - If en = 0: go to IDLE with busy = 0.
- start while busy is ignored, not queued.
- Changes to ch_mask mid-sweep are ignored until the next sweep start.
- en deasserted mid-sweep: the current sweep completes normally, then the FSM goes IDLE.
- Reset mid-operation: trigger clears immediately (asynchronously). After reset release the FSM is IDLE and needs a new start or en.
- Invariant: the trigger output is one-hot or zero at all times.

Test Plan:
All scenarios use CLK_FREQ=4_000_000, NUM_CH=4, PULSE_US=2, SLOT_US=5, giving PULSE_CYC=8 and SLOT_CYC=20. Cycle 0 is the edge that samples start/en.
- Reset: hold rst=1 for 2 cycles -> trigger=0, trigger_tick=0, busy=0, sweep_done=0, ch_idx=0.
- One-shot sweep, start pulse with ch_mask=4'b1011:
  - trigger[0] high cycles 1-8; trigger[1] high cycles 21-28; trigger[3] high cycles 41-48.
  - trigger_tick at 1, 21 and 41; ch_idx = 0, 1, 3.
  - sweep_done at 61; busy is 1 for cycles 1-60 and 0 from 61.
- Periodic mode, en=1 with ch_mask=4'b0001:
  - trigger[0] rises at 1, 21, 41, ...; busy is never low between sweeps.
  - sweep_done at 21, 41, ..., coinciding with trigger_tick.
  - Drop en at cycle 30 -> last pulse is at 21, sweep_done at 41, no trigger at 41, busy=0 from 41.
- Empty mask: start with ch_mask=0 -> trigger stays 0, sweep_done=1 at cycle 1 only, busy stays 0.
- Mid-sweep inputs during the 4'b1011 sweep:
  - ch_mask changed to 4'b0100 at cycle 10 -> channels 1 and 3 still fire as in the one-shot scenario.
  - start pulsed again at cycle 15 -> no extra sweep; sweep_done still at 61 only.
- Asynchronous reset: assert rst at cycle 4 (mid-pulse), between clock edges -> trigger[0] clears before the next edge. After release with no start, trigger stays 0 for 50 cycles.
